// File: rtl/hs_rx_pkg.sv
// Shared types and helpers for the handshake receiver endpoint.
package hs_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_rx_state_e;

  localparam int XFER_COUNT_W = 16;

  // Pointer carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flipflop_synchronizer.sv
// Multi-stage flip-flop synchronizer for signals entering the local clock domain.
module flipflop_synchronizer #(
  parameter int WIDTH         = 1,
  parameter int NUM_OF_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] sync_data
);

  logic [WIDTH-1:0] stage_q [NUM_OF_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_data;
      for (int i = 1; i < NUM_OF_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_data = stage_q[NUM_OF_STAGES-1];

endmodule

// File: rtl/handshake_receiver_endpoint.sv
// Destination side of a four-phase req/ack CDC handshake feeding a small FIFO.
// Optional transfer counter enabled with `define HS_RX_XFER_COUNT_EN.
module handshake_receiver_endpoint
  import hs_rx_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int NUM_SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ack_o,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    full,
  output logic [XFER_COUNT_W-1:0] xfer_count,
  output hs_rx_state_e            dbg_state
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic sync_req;

  flipflop_synchronizer #(
    .WIDTH        (1),
    .NUM_OF_STAGES(NUM_SYNC_STAGES)
  ) u_req_sync (
    .clock     (clock),
    .reset     (reset),
    .async_data(req_i),
    .sync_data (sync_req)
  );

  // The sync chain is cleared by reset, so sync_req only reflects the real
  // req_i once the chain has refilled; arming waits for that before looking
  // for a low request, so a request held across reset is never captured.
  logic [NUM_SYNC_STAGES-1:0] settle_sr;
  logic                       armed;

  always_ff @(posedge clock) begin
    if (reset) begin
      settle_sr <= '0;
      armed     <= 1'b0;
    end else begin
      settle_sr <= {settle_sr[NUM_SYNC_STAGES-2:0], 1'b1};
      if (settle_sr[NUM_SYNC_STAGES-1] && !sync_req) armed <= 1'b1;
    end
  end

  hs_rx_state_e state_q, state_d;
  logic         ack_d;
  logic         push;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && sync_req && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (sync_req) ack_d = 1'b1;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ack_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_o   <= ack_d;
    end
  end

  assign dbg_state = state_q;

  // Downstream valid/ready: a word transfers on any edge where out_valid and
  // out_ready are both high; out_data is held stable while out_valid waits.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic                  pop;

  assign pop        = out_valid && out_ready;
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  // The output register looks at pre-edge write state, so a fresh word shows
  // up one edge after its push while a pop takes effect on its own edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_ptr_nxt;
      out_valid <= (wr_ptr != rd_ptr_nxt);
      out_data  <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

`ifdef HS_RX_XFER_COUNT_EN
  logic [XFER_COUNT_W-1:0] xfer_count_q;

  always_ff @(posedge clock) begin
    if (reset)     xfer_count_q <= '0;
    else if (push) xfer_count_q <= xfer_count_q + XFER_COUNT_W'(1);
  end

  assign xfer_count = xfer_count_q;
`else
  assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_handshake_receiver_endpoint.sv
// Directed bench for handshake_receiver_endpoint: cycle table plus multi-cycle sequences.
module tb_handshake_receiver_endpoint;
  import hs_rx_pkg::*;

  localparam int DW = 32;

`ifdef HS_RX_XFER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    req_i = 1'b0;
  logic [DW-1:0]           data_i = '0;
  logic                    ack_o;
  logic                    out_valid;
  logic [DW-1:0]           out_data;
  logic                    out_ready = 1'b0;
  logic                    full;
  logic [XFER_COUNT_W-1:0] xfer_count;
  hs_rx_state_e            dbg_state;

  handshake_receiver_endpoint #(
    .DATA_WIDTH(DW), .DEPTH(4), .NUM_SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .full(full), .xfer_count(xfer_count),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: words leave on the edge after a negedge that sees valid&ready
  always @(negedge clock) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h with nothing expected", out_data);
      end else begin
        check("drain_order", {32'h0, out_data}, {32'h0, exp_q.pop_front()});
        rx_count++;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input logic level, input int budget, input string name);
    int n = 0;
    while (ack_o !== level && n < budget) begin
      step();
      n++;
    end
    check(name, {63'h0, ack_o}, {63'h0, level});
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    exp_q.push_back(d);
    data_i = d;
    req_i  = 1'b1;
    wait_ack(1'b1, 20, "send_ack_rise");
    req_i  = 1'b0;
    wait_ack(1'b0, 20, "send_ack_fall");
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'h0);
  endtask

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    logic          rdy;
    logic          ack;
    logic          valid;
    logic          chk_data;
    logic [DW-1:0] odata;
    logic          full;
  } vec_t;

  vec_t vecs[15];

  initial begin
    bit seen_ack;
    bit seen_valid;

    // single transfer (rdy=1) then a held word (rdy=0) popped at the end
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[11] = '{1'b0, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[12] = '{1'b0, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[13] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[14] = '{1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};

    // reset state
    reset = 1'b1;
    steps(2);
    check("rst_ack",   {63'h0, ack_o},     64'h0);
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_data",  {32'h0, out_data},  64'h0);
    check("rst_full",  {63'h0, full},      64'h0);
    check("rst_count", {48'h0, xfer_count}, 64'h0);
    check("rst_state", {63'h0, dbg_state}, {63'h0, IDLE});
    reset = 1'b0;
    steps(4);

    // cycle-exact table
    for (int i = 0; i < 15; i++) begin
      req_i     = vecs[i].req;
      data_i    = vecs[i].data;
      out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_ack", i),   {63'h0, ack_o},     {63'h0, vecs[i].ack});
      check($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].valid});
      check($sformatf("vec%0d_full", i),  {63'h0, full},      {63'h0, vecs[i].full});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), {32'h0, out_data}, {32'h0, vecs[i].odata});
    end
    check("table_count", {48'h0, xfer_count}, CNT_EN ? 64'd2 : 64'd0);

    // backpressure: four words fill the FIFO, fifth stalls
    do_reset();
    steps(4);
    mon_en    = 1'b1;
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) send_word(DW'(w));
    check("bp_full_after_4", {63'h0, full}, 64'h1);
    exp_q.push_back(32'h5);
    data_i   = 32'h5;
    req_i    = 1'b1;
    seen_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack_o) seen_ack = 1'b1;
    end
    check("bp_fifth_no_ack", {63'h0, seen_ack}, 64'h0);
    check("bp_state_idle", {63'h0, dbg_state}, {63'h0, IDLE});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_full_after_pop", {63'h0, full}, 64'h0);
    check("bp_ack_before_capture", {63'h0, ack_o}, 64'h0);
    step();
    check("bp_fifth_acked", {63'h0, ack_o}, 64'h1);
    check("bp_full_again", {63'h0, full}, 64'h1);
    req_i = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    out_ready = 1'b1;
    wait_drain(40);
    steps(2);
    check("bp_empty", {63'h0, out_valid}, 64'h0);
    out_ready = 1'b0;

    // held request: exactly one capture
    do_reset();
    steps(4);
    exp_q.push_back(32'h77);
    data_i = 32'h77;
    req_i  = 1'b1;
    steps(50);
    check("held_ack_high", {63'h0, ack_o}, 64'h1);
    check("held_count", {48'h0, xfer_count}, CNT_EN ? 64'd1 : 64'd0);
    rx_count  = 0;
    out_ready = 1'b1;
    steps(5);
    check("held_one_word", 64'(rx_count), 64'd1);
    check("held_empty", {63'h0, out_valid}, 64'h0);
    req_i = 1'b0;
    wait_ack(1'b0, 20, "held_ack_fall");

    // request already high across reset
    data_i = 32'h99;
    req_i  = 1'b1;
    do_reset();
    seen_ack   = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_o) seen_ack = 1'b1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rsthi_no_ack", {63'h0, seen_ack}, 64'h0);
    check("rsthi_no_push", {63'h0, seen_valid}, 64'h0);
    req_i = 1'b0;
    steps(5);
    send_word(32'h99);
    wait_drain(20);

    // pointer wrap: ten back-to-back words
    do_reset();
    steps(4);
    rx_count  = 0;
    out_ready = 1'b1;
    for (int w = 0; w < 10; w++) send_word(32'hA0 + DW'(w));
    wait_drain(40);
    check("wrap_rx_count", 64'(rx_count), 64'd10);
    check("wrap_count", {48'h0, xfer_count}, CNT_EN ? 64'd10 : 64'd0);

    // reset while in ACK with two words buffered
    do_reset();
    steps(4);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    send_word(32'hB0);
    data_i = 32'hB1;
    req_i  = 1'b1;
    wait_ack(1'b1, 20, "mid_ack_rise");
    step();
    check("mid_state_ack", {63'h0, dbg_state}, {63'h0, ACK});
    reset = 1'b1;
    step();
    check("mid_ack", {63'h0, ack_o}, 64'h0);
    check("mid_valid", {63'h0, out_valid}, 64'h0);
    check("mid_full", {63'h0, full}, 64'h0);
    check("mid_state", {63'h0, dbg_state}, {63'h0, IDLE});
    check("mid_count", {48'h0, xfer_count}, 64'h0);
    reset = 1'b0;
    req_i = 1'b0;
    exp_q.delete();
    steps(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
